matrix_packer: RTL and testbench
================================

MATRIX_PACKER -- requirements
Module: matrix_packer

Interface
REQ-001 The block SHALL have no parameters; matrix geometry is fixed at 5 columns x 5 rows, 8 bits per element, 25 elements per 200-bit bus.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low; ports: clk input 1 (rising-edge clock), rst_n input 1 (asynchronous active-low reset).
REQ-003 The block SHALL provide: start input 1, single-cycle request to begin a new load.
REQ-004 The block SHALL provide: matrix_size input 2, with 00=2x2, 01=3x3, 10=4x4 and 11=5x5, sampled only when start is accepted.
REQ-005 The block SHALL provide: in_valid input 1, in_data input 8 and in_ready output 1, forming the byte-stream handshake.
REQ-006 The block SHALL provide: kernel output 200 (packed signed kernel bytes) and pixel output 200 (packed unsigned pixel bytes).
REQ-007 The block SHALL provide: size_out output 2, the latched matrix_size.
REQ-008 The block SHALL provide: out_valid output 1 and out_ready input 1, forming the matrix handoff to the convolution unit.
REQ-009 The block SHALL provide: busy output 1, high in every state except IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, LOAD_K, LOAD_P and HOLD.
REQ-011 In IDLE, start=1 SHALL latch matrix_size into size_out, zero both kernel and pixel, clear the counters and enter LOAD_K on the next edge.
REQ-012 start SHALL be ignored in every state except IDLE.
REQ-013 in_ready SHALL be 1 exactly in LOAD_K and LOAD_P, and 0 otherwise.
REQ-014 A byte SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; no other edge SHALL change kernel or pixel except the clear in REQ-011.
REQ-015 Bytes SHALL arrive row-major, with N = size_out + 2 elements per row and per column.
REQ-016 The byte at (row, col) SHALL be written to bits [(row*5+col)*8 +: 8] of the active bus.
REQ-017 Positions with row >= N or col >= N SHALL remain zero.
REQ-018 The column counter SHALL wrap from N-1 to 0 and increment row; after byte (N-1, N-1) both counters SHALL reset to 0.
REQ-019 LOAD_K SHALL fill kernel; after its N*N-th accepted byte the FSM SHALL enter LOAD_P on that same edge.
REQ-020 LOAD_P SHALL fill pixel; after its N*N-th accepted byte the FSM SHALL enter HOLD on that same edge.
REQ-021 in_valid=0 during a load SHALL stall the load with no state or counter change; gaps of any length SHALL be allowed.
REQ-022 out_valid SHALL be 1 exactly in HOLD, and kernel, pixel and size_out SHALL be stable throughout HOLD.
REQ-023 out_valid=1 with out_ready=1 SHALL complete the handoff and return the FSM to IDLE on that edge.
REQ-024 kernel, pixel and size_out SHALL keep their last values in IDLE until the next accepted start.
REQ-025 out_ready asserted outside HOLD SHALL have no effect.
REQ-026 Minimum latency SHALL be 1 + 2*N*N + 1 cycles from start to the handoff edge: 10 for 2x2, 52 for 5x5.
REQ-027 A start pulse asserted on the handoff edge SHALL be ignored; a new load SHALL require start while in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock, force IDLE, counters 0, kernel=0, pixel=0, size_out=00, in_ready=0, out_valid=0 and busy=0.
REQ-029 Reset asserted mid-load or during HOLD SHALL discard the partial or pending matrix with no handoff.
REQ-030 After rst_n deasserts, the first accepted start SHALL behave exactly as in REQ-011.

Verification
REQ-031 2x2 test: start with size 00, then kernel bytes 01,02,03,04 and pixel bytes 10,20,30,40 streamed back-to-back -> kernel bytes 0,1,5,6 = 01,02,03,04 and pixel bytes 0,1,5,6 = 10,20,30,40, all other bytes 00, out_valid rises 9 cycles after start.
REQ-032 5x5 test: start with size 11, kernel byte i = i and pixel byte i = 0x80+i for i = 0..24, with out_ready held 1 -> the full buses are filled with no zero bytes, and busy falls on cycle 52 after start.
REQ-033 Stall and backpressure test: 3x3 load with in_valid=0 for 5 cycles after byte 4, then out_ready held 0 for 20 cycles -> bytes land at indices 0,1,2,5,6,7,10,11,12, and the buses and out_valid stay stable until out_ready=1.
REQ-034 Reset mid-operation test: rst_n pulsed low during LOAD_P of a 4x4 load -> all outputs are zero asynchronously, the FSM returns to IDLE, and a subsequent 2x2 load packs correctly with no residue from the aborted load.
REQ-035 Ignored-input test: start pulsed during LOAD_K and on the handoff edge, and in_valid pulsed in IDLE -> none of these change the FSM, counters or buses.

Source files
------------

// File: rtl/matrix_packer.sv
// Byte-stream to matrix packer: loads an NxN signed kernel then an NxN unsigned pixel
// block (N = 2..5) into fixed 5x5 row-major buses and hands both to the convolution unit.
module matrix_packer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   matrix_size,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [199:0] kernel,
    output logic [199:0] pixel,
    output logic [1:0]   size_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int DATA_W = 8;
    localparam int GRID   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_K = 2'd1,
        LOAD_P = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] n_dim;
    logic [4:0] elem_idx;
    logic [7:0] bit_off;
    logic       start_acc;
    logic       accept;
    logic       last_col;
    logic       last_row;
    logic       last_elem;

    assign n_dim     = {1'b0, size_out} + 3'd2;
    assign start_acc = (state == IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign last_col  = (col == n_dim - 3'd1);
    assign last_row  = (row == n_dim - 3'd1);
    assign last_elem = last_col && last_row;

    // Row stride is always the full 5-element grid width, independent of N.
    assign elem_idx = ({2'b00, row} * 5'(GRID)) + {2'b00, col};
    assign bit_off  = {elem_idx, 3'b000};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD_K;
                end
            end
            LOAD_K: begin
                in_ready = 1'b1;
                if (accept && last_elem) begin
                    state_nxt = LOAD_P;
                end
            end
            LOAD_P: begin
                in_ready = 1'b1;
                if (accept && last_elem) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters wrap to 0,0 after the last element so the pixel phase starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (start_acc) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (accept) begin
            if (last_col) begin
                col <= 3'd0;
                row <= last_row ? 3'd0 : row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_out <= 2'b00;
            kernel   <= '0;
            pixel    <= '0;
        end else if (start_acc) begin
            size_out <= matrix_size;
            kernel   <= '0;
            pixel    <= '0;
        end else if (accept) begin
            if (state == LOAD_K) begin
                kernel[bit_off +: DATA_W] <= in_data;
            end else begin
                pixel[bit_off +: DATA_W] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_packer.sv
// Bench for matrix_packer: phase/byte-count reference model compared every cycle,
// plus directed loads with hand-computed bus contents and latencies.
module tb_matrix_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   matrix_size;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [199:0] kernel;
    logic [199:0] pixel;
    logic [1:0]   size_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    matrix_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .matrix_size (matrix_size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .kernel      (kernel),
        .pixel       (pixel),
        .size_out    (size_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 kernel, 2 pixel, 3 hold; cnt = bytes taken in phase.
    int           ph;
    int           cnt;
    logic [199:0] mk;
    logic [199:0] mp;
    logic [1:0]   ms;

    function automatic int n_of(input logic [1:0] s);
        return int'(s) + 2;
    endfunction

    function automatic int pos_of(input int c, input int n);
        return (c / n) * 5 + (c % n);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph  <= 0;
            cnt <= 0;
            mk  <= '0;
            mp  <= '0;
            ms  <= 2'b00;
        end else begin
            case (ph)
                0: if (start) begin
                    ms  <= matrix_size;
                    mk  <= '0;
                    mp  <= '0;
                    cnt <= 0;
                    ph  <= 1;
                end
                1, 2: if (in_valid) begin
                    if (ph == 1) mk[pos_of(cnt, n_of(ms)) * 8 +: 8] <= in_data;
                    else         mp[pos_of(cnt, n_of(ms)) * 8 +: 8] <= in_data;
                    if (cnt + 1 == n_of(ms) * n_of(ms)) begin
                        cnt <= 0;
                        ph  <= ph + 1;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                3: if (out_ready) ph <= 0;
                default: ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  in_ready,  (ph == 1 || ph == 2));
            chk("out_valid", out_valid, (ph == 3));
            chk("busy",      busy,      (ph != 0));
            chk("size_out",  size_out,  ms);
            chk("kernel",    kernel,    mk);
            chk("pixel",     pixel,     mp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] s);
        start       = 1'b1;
        matrix_size = s;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [199:0] k_snap;
        logic [199:0] p_snap;
        int           idx_tab [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int           nz;

        rst_n = 1'b0; start = 1'b0; matrix_size = 2'b00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst_kernel", kernel, '0);
        chk("rst_pixel",  pixel,  '0);
        chk("rst_busy",   busy,   1'b0);
        chk("rst_ready",  in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2x2 back-to-back load, in_valid pulse in IDLE first
        send(8'hff);
        chk("idle_inv_kernel", kernel, '0);
        do_start(2'b00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h10); send(8'h20); send(8'h30);
        chk("ov_before_c9", out_valid, 1'b0);
        send(8'h40);
        chk("ov_at_c9", out_valid, 1'b1);
        chk("k2x2_lit", kernel, {144'h0, 8'h04, 8'h03, 24'h0, 8'h02, 8'h01});
        chk("p2x2_lit", pixel,  {144'h0, 8'h40, 8'h30, 24'h0, 8'h20, 8'h10});
        // start on the handoff edge is ignored
        out_ready = 1'b1; start = 1'b1; matrix_size = 2'b11;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("handoff_busy", busy, 1'b0);
        chk("handoff_size", size_out, 2'b00);
        tick();
        chk("start_on_handoff_ignored", busy, 1'b0);
        send(8'h77);
        chk("idle_keep_kernel", kernel, {144'h0, 8'h04, 8'h03, 24'h0, 8'h02, 8'h01});

        // 5x5 with out_ready held high throughout
        out_ready = 1'b1;
        do_start(2'b11);
        for (int i = 0; i < 25; i++) send(8'(i));
        for (int i = 0; i < 25; i++) send(8'(8'h80 + i));
        chk("busy_c51", busy, 1'b1);
        chk("k5_last",  kernel[199:192], 8'h18);
        chk("k5_b12",   kernel[103:96],  8'h0c);
        chk("p5_first", pixel[7:0],      8'h80);
        chk("p5_last",  pixel[199:192],  8'h98);
        nz = 0;
        for (int i = 0; i < 25; i++) if (pixel[i*8 +: 8] != 8'h00) nz++;
        chk("p5_nonzero_cnt", nz, 25);
        tick();
        chk("busy_fall_c52", busy, 1'b0);
        out_ready = 1'b0;
        tick();

        // 3x3 with stall after 4 bytes, ignored start during LOAD_K, then backpressure
        do_start(2'b01);
        for (int i = 0; i < 4; i++) send(8'(8'h21 + i));
        tick();
        start = 1'b1; matrix_size = 2'b00;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("stall_size", size_out, 2'b01);
        chk("stall_ready", in_ready, 1'b1);
        for (int i = 4; i < 9; i++) send(8'(8'h21 + i));
        for (int i = 0; i < 9; i++) send(8'(8'h31 + i));
        k_snap = kernel;
        p_snap = pixel;
        for (int i = 0; i < 9; i++) begin
            chk("k3_idx", kernel[idx_tab[i]*8 +: 8], 8'(8'h21 + i));
            chk("p3_idx", pixel[idx_tab[i]*8 +: 8],  8'(8'h31 + i));
        end
        nz = 0;
        for (int i = 0; i < 25; i++) if (kernel[i*8 +: 8] != 8'h00) nz++;
        chk("k3_nonzero_cnt", nz, 9);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_kernel", kernel, k_snap);
            chk("bp_pixel",  pixel,  p_snap);
            chk("bp_ov",     out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", out_valid, 1'b0);

        // 4x4 aborted by reset during LOAD_P, then clean 2x2
        do_start(2'b10);
        for (int i = 0; i < 16; i++) send(8'(8'h41 + i));
        for (int i = 0; i < 5; i++)  send(8'(8'h61 + i));
        chk("pre_rst_ready", in_ready, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_kernel", kernel, '0);
        chk("async_pixel",  pixel,  '0);
        chk("async_size",   size_out, 2'b00);
        chk("async_ready",  in_ready, 1'b0);
        chk("async_busy",   busy,   1'b0);
        chk("async_ov",     out_valid, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        do_start(2'b00);
        send(8'h0a); send(8'h0b); send(8'h0c); send(8'h0d);
        send(8'ha0); send(8'ha1); send(8'ha2); send(8'ha3);
        chk("post_rst_k", kernel, {144'h0, 8'h0d, 8'h0c, 24'h0, 8'h0b, 8'h0a});
        chk("post_rst_p", pixel,  {144'h0, 8'ha3, 8'ha2, 24'h0, 8'ha1, 8'ha0});
        chk("post_rst_ov", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
